// File: rtl/adder_pipe.sv
// adder_pipe: segmented, pipelined carry-propagate adder with valid/ready handshakes.
//
// Each of STAGES register stages adds one WIDTH/STAGES-bit segment of the operands.
// The carry and the operand bits not yet consumed travel with the transaction through
// the pipeline. A transaction accepted at edge t is presented on sum/out_valid after
// edge t+STAGES-1. Throughput is one result per cycle.
//
// Parameters:
//   WIDTH        operand width; must be a multiple of STAGES
//   STAGES       number of pipeline stages
//   APPROX_BITS  approximated LSBs of stage 0; only meaningful with ADDER_APPROX_EN
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; flushes every stage
//   in_valid   a, b, cin valid
//   in_ready   block accepts operands this cycle (pipeline advance enable)
//   a, b       unsigned operands
//   cin        carry-in (ignored in the approximate build)
//   out_valid  sum valid
//   out_ready  downstream accepts sum
//   sum        result; sum[WIDTH] is the carry-out
//
// Build option:
//   ADDER_APPROX_EN  when defined, stage 0 uses a lower-part-OR adder on the low
//                    APPROX_BITS bits. Handshake and latency are unchanged.

module adder_pipe #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned STAGES      = 2,
    parameter int unsigned APPROX_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);

    localparam int unsigned SEG = WIDTH / STAGES;

    // Elaboration-time parameter checks.
    if (STAGES == 0 || (WIDTH % STAGES) != 0) begin : gen_chk_width
        $error("adder_pipe: WIDTH must be a non-zero multiple of STAGES");
    end

    // Per-stage state. acc holds the sum bits of all segments consumed so far;
    // opa/opb carry the full operands so later stages can pick their segment.
    logic [STAGES-1:0]            vld_q, vld_d;
    logic [STAGES-1:0]            cy_q, cy_d;
    logic [STAGES-1:0][WIDTH-1:0] acc_q, acc_d;
    logic [STAGES-1:0][WIDTH-1:0] opa_q, opa_d;
    logic [STAGES-1:0][WIDTH-1:0] opb_q, opb_d;

    logic           adv;
    logic [SEG-1:0] s0_sum;
    logic           s0_cy;
    logic [SEG:0]   seg_sum;

    // ------------------------------------------------------------------
    // Stage 0 segment adder
    // ------------------------------------------------------------------
`ifdef ADDER_APPROX_EN
    if (APPROX_BITS == 0 || APPROX_BITS >= SEG) begin : gen_chk_approx
        $error("adder_pipe: APPROX_BITS must be in 1 .. WIDTH/STAGES-1");
    end

    logic [SEG-APPROX_BITS:0] s0_hi;
    logic                     unused_cin;

    // Low bits are OR-ed; the carry into the exact upper part is guessed from the
    // top approximated bit pair only.
    always_comb begin
        s0_hi = {1'b0, a[SEG-1:APPROX_BITS]}
              + {1'b0, b[SEG-1:APPROX_BITS]}
              + {{(SEG-APPROX_BITS){1'b0}}, a[APPROX_BITS-1] & b[APPROX_BITS-1]};
        s0_sum = {s0_hi[SEG-APPROX_BITS-1:0], a[APPROX_BITS-1:0] | b[APPROX_BITS-1:0]};
        s0_cy  = s0_hi[SEG-APPROX_BITS];
    end

    assign unused_cin = cin;
`else
    localparam int unsigned unused_approx_bits = APPROX_BITS;

    logic [SEG:0] s0_full;

    always_comb begin
        s0_full = {1'b0, a[SEG-1:0]} + {1'b0, b[SEG-1:0]} + {{SEG{1'b0}}, cin};
        s0_sum  = s0_full[SEG-1:0];
        s0_cy   = s0_full[SEG];
    end
`endif

    // ------------------------------------------------------------------
    // Advance enable and next state
    // ------------------------------------------------------------------
    // Reset forces the pipeline to look empty so in_ready reads 1 while rst is high;
    // the state registers are cleared regardless of what is presented.
    always_comb begin
        adv = rst || !vld_q[STAGES-1] || out_ready;
    end

    always_comb begin
        vld_d   = vld_q;
        cy_d    = cy_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        seg_sum = '0;

        if (adv) begin
            vld_d[0]           = in_valid;
            cy_d[0]            = s0_cy;
            acc_d[0]           = '0;
            acc_d[0][SEG-1:0]  = s0_sum;
            opa_d[0]           = a;
            opb_d[0]           = b;

            for (int k = 1; k < STAGES; k++) begin
                seg_sum = {1'b0, opa_q[k-1][k*SEG +: SEG]}
                        + {1'b0, opb_q[k-1][k*SEG +: SEG]}
                        + {{SEG{1'b0}}, cy_q[k-1]};
                vld_d[k]                = vld_q[k-1];
                cy_d[k]                 = seg_sum[SEG];
                acc_d[k]                = acc_q[k-1];
                acc_d[k][k*SEG +: SEG]  = seg_sum[SEG-1:0];
                opa_d[k]                = opa_q[k-1];
                opb_d[k]                = opb_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            acc_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            acc_q <= acc_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
        end
    end

    // Already-consumed operand segments are carried for simplicity but never read.
    logic unused_ops;
    assign unused_ops = ^{opa_q, opb_q};

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = {cy_q[STAGES-1], acc_q[STAGES-1]};

endmodule

// File: tb/tb_adder_pipe.sv
module tb_adder_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-bit, 2-stage instance
    logic       v8, r8, cin8, ov8, ordy8;
    logic [7:0] a8, b8;
    logic [8:0] sum8;

    // 16-bit, 4-stage instance
    logic        v16, r16, cin16, ov16, ordy16;
    logic [15:0] a16, b16;
    logic [16:0] sum16;

    adder_pipe #(.WIDTH(8), .STAGES(2), .APPROX_BITS(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8), .cin(cin8),
        .out_valid(ov8), .out_ready(ordy8), .sum(sum8)
    );

    adder_pipe #(.WIDTH(16), .STAGES(4), .APPROX_BITS(2)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16), .cin(cin16),
        .out_valid(ov16), .out_ready(ordy16), .sum(sum16)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on whole operands. The approximate variant ORs the
    // low 2 bits and adds the upper part with a carry guessed from bit 1.
    function automatic logic [31:0] ref_sum(input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] c);
`ifdef ADDER_APPROX_EN
        logic [31:0] guess;
        guess = (x >> 1) & (y >> 1) & 32'd1;
        ref_sum = (((x >> 2) + (y >> 2) + guess) << 2) | ((x | y) & 32'd3);
        if (c > 32'd1) ref_sum = 32'hFFFF_FFFF;  // cin is ignored; guard against misuse
`else
        ref_sum = x + y + c;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] exp;  // exact-build result
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [31:0] e, e0, e1, e2, hold_sum;
        logic [31:0] q[$];
        int in_cnt, out_cnt, cyc;
        logic acc_in, acc_out, acc_prev;
        localparam int N = 10000;

        tbl[0] = '{8'h0F, 8'h01, 1'b0, 9'h010};
        tbl[1] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
        tbl[2] = '{8'h80, 8'h80, 1'b0, 9'h100};
        tbl[3] = '{8'h05, 8'h03, 1'b1, 9'h009};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 9'h000};
        tbl[5] = '{8'hFF, 8'h00, 1'b1, 9'h100};

        rst = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; ordy8 = 1'b1;
        v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; ordy16 = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_out_valid8", 32'(ov8), 32'd0);
        check("rst_sum8", 32'(sum8), 32'd0);
        check("rst_in_ready8", 32'(r8), 32'd1);
        check("rst_out_valid16", 32'(ov16), 32'd0);
        check("rst_sum16", 32'(sum16), 32'd0);

        // Single transfers: latency and value
        for (int i = 0; i < 6; i++) begin
`ifdef ADDER_APPROX_EN
            e = ref_sum(32'(tbl[i].a), 32'(tbl[i].b), 32'(tbl[i].cin));
`else
            e = 32'(tbl[i].exp);
`endif
            v8 = 1'b1; a8 = tbl[i].a; b8 = tbl[i].b; cin8 = tbl[i].cin;
            tick();
            v8 = 1'b0;
            check("lat_early", 32'(ov8), 32'd0);
            tick();
            check("lat_valid", 32'(ov8), 32'd1);
            check("vec_sum", 32'(sum8), e);
            tick();
            check("vec_drained", 32'(ov8), 32'd0);
        end

        // Back-to-back transfers
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        tick();
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        tick();
        v8 = 1'b0;
        check("b2b_valid0", 32'(ov8), 32'd1);
        check("b2b_sum0", 32'(sum8), ref_sum(32'hFF, 32'hFF, 32'd1));
        tick();
        check("b2b_valid1", 32'(ov8), 32'd1);
        check("b2b_sum1", 32'(sum8), ref_sum(32'h80, 32'h80, 32'd0));
        tick();
        check("b2b_empty", 32'(ov8), 32'd0);

        // Backpressure: fill, stall four cycles, release
        e0 = ref_sum(32'h12, 32'h34, 32'd0);
        e1 = ref_sum(32'hAA, 32'h55, 32'd1);
        e2 = ref_sum(32'h7F, 32'h01, 32'd0);
        ordy8 = 1'b0;
        v8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        tick();
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
        tick();
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        #1;
        hold_sum = 32'(sum8);
        check("stall_first", hold_sum, e0);
        for (int i = 0; i < 4; i++) begin
            check("stall_in_ready", 32'(r8), 32'd0);
            check("stall_valid", 32'(ov8), 32'd1);
            check("stall_sum", 32'(sum8), e0);
            tick();
        end
        ordy8 = 1'b1;
        #1;
        check("release_in_ready", 32'(r8), 32'd1);
        tick();
        v8 = 1'b0;
        check("release_valid1", 32'(ov8), 32'd1);
        check("release_sum1", 32'(sum8), e1);
        tick();
        check("release_valid2", 32'(ov8), 32'd1);
        check("release_sum2", 32'(sum8), e2);
        tick();
        check("release_empty", 32'(ov8), 32'd0);

        // Reset with two transfers in flight
        v8 = 1'b1; a8 = 8'h21; b8 = 8'h43; cin8 = 1'b0;
        tick();
        a8 = 8'h65; b8 = 8'h87; cin8 = 1'b1;
        tick();
        v8 = 1'b0;
        ordy8 = 1'b0;
        #1;
        check("pre_rst_valid", 32'(ov8), 32'd1);
        check("pre_rst_in_ready", 32'(r8), 32'd0);
        rst = 1'b1;
        v8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        #1;
        check("rst_in_ready_hi", 32'(r8), 32'd1);
        tick();
        rst = 1'b0;
        v8 = 1'b0;
        ordy8 = 1'b1;
        check("post_rst_valid", 32'(ov8), 32'd0);
        check("post_rst_sum", 32'(sum8), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_stale", 32'(ov8), 32'd0);
        end

        // Random traffic on the 16-bit, 4-stage instance
        in_cnt = 0; out_cnt = 0; cyc = 0; acc_prev = 1'b0;
        while (out_cnt < N && cyc < 60000) begin
            if (!(v16 && !acc_prev)) begin
                if (in_cnt < N && $urandom_range(3) != 0) begin
                    v16 = 1'b1;
                    a16 = 16'($urandom);
                    b16 = 16'($urandom);
                    cin16 = 1'($urandom_range(1));
                end else begin
                    v16 = 1'b0;
                end
            end
            ordy16 = ($urandom_range(3) != 0);
            #1;
            acc_in  = v16 && r16;
            acc_out = ov16 && ordy16;
            if (acc_out) begin
                if (q.size() == 0) begin
                    check("rnd_spurious", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("rnd_sum", 32'(sum16), e);
                end
                out_cnt++;
            end
            if (acc_in) begin
                q.push_back(ref_sum(32'(a16), 32'(b16), 32'(cin16)));
                in_cnt++;
            end
            acc_prev = acc_in;
            tick();
            cyc++;
        end
        v16 = 1'b0;
        ordy16 = 1'b1;
        check("rnd_out_count", 32'(out_cnt), 32'(N));
        check("rnd_queue_empty", 32'(q.size()), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rnd_no_extra", 32'(ov16), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
